// File: rtl/pc_if.sv
// Fetch-control bundle between the pipeline front end and the program-counter unit.
// The master side drives next-PC controls; the slave side (pc_unit) returns fetch state.
interface pc_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            call;
   logic            ret;
   logic            trap;
   logic            mret;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] epc;
   logic            misalign_fault;
   logic            ras_empty;

   modport master (
      output stall, redirect_valid, redirect_target, call, ret, trap, mret,
      input  pc, pc_valid, epc, misalign_fault, ras_empty
   );

   modport slave (
      input  stall, redirect_valid, redirect_target, call, ret, trap, mret,
      output pc, pc_valid, epc, misalign_fault, ras_empty
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection (trap, mret, redirect, stall,
// RAS return, sequential), exception PC capture and a circular return-address stack.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              INC          = 4,
   parameter int              ALIGN_BITS   = 2,
   parameter int              RAS_DEPTH    = 4
) (
   input logic clk,
   input logic rst,
   pc_if.slave bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

   typedef logic [XLEN-1:0] addr_t;

   addr_t            pc_cur, epc_cur, pc_next, epc_next, seq_pc, ras_top;
   logic             valid_cur, fault_cur, fault_next, empty_cur;
   logic             push, pop, misaligned;
   logic [PTR_W-1:0] ptr, ptr_next, top_idx;
   logic [PTR_W:0]   count, count_next;
   addr_t            ras_mem [RAS_DEPTH];

   assign seq_pc     = pc_cur + addr_t'(INC);
   assign top_idx    = ptr - PTR_W'(1);
   assign ras_top    = ras_mem[top_idx];
   assign misaligned = |bus.redirect_target[ALIGN_BITS-1:0];

   // Next-PC priority; the first cycle after reset only raises pc_valid.
   always_comb begin
      pc_next    = pc_cur;
      epc_next   = epc_cur;
      fault_next = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      if (valid_cur) begin
         if (bus.trap) begin
            epc_next = pc_cur;
            pc_next  = TRAP_VECTOR;
         end else if (bus.mret) begin
            pc_next = epc_cur;
         end else if (bus.redirect_valid && misaligned) begin
            epc_next   = bus.redirect_target;
            pc_next    = TRAP_VECTOR;
            fault_next = 1'b1;
         end else if (bus.redirect_valid) begin
            pc_next = bus.redirect_target;
         end else if (!bus.stall) begin
            if (bus.ret && !empty_cur) begin
               pc_next = ras_top;
               pop     = 1'b1;
            end else begin
               pc_next = seq_pc;
            end
            push = bus.call;
         end
      end
   end

   // Push+pop together replaces the top entry, so pointer and count stay put.
   always_comb begin
      ptr_next   = ptr;
      count_next = count;
      if (push && !pop) begin
         ptr_next   = ptr + PTR_W'(1);
         count_next = (count == FULL) ? count : count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         ptr_next   = top_idx;
         count_next = count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_cur    <= RESET_VECTOR;
         epc_cur   <= '0;
         valid_cur <= 1'b0;
         fault_cur <= 1'b0;
         ptr       <= '0;
         count     <= '0;
         empty_cur <= 1'b1;
      end else begin
         pc_cur    <= pc_next;
         epc_cur   <= epc_next;
         valid_cur <= 1'b1;
         fault_cur <= fault_next;
         ptr       <= ptr_next;
         count     <= count_next;
         empty_cur <= (count_next == '0);
      end
   end

   // Stack storage needs no reset: entries are only read when count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_mem[pop ? top_idx : ptr] <= seq_pc;
      end
   end

   assign bus.pc             = pc_cur;
   assign bus.pc_valid       = valid_cur;
   assign bus.epc            = epc_cur;
   assign bus.misalign_fault = fault_cur;
   assign bus.ras_empty      = empty_cur;
endmodule
